spin_credit_controller: RTL and testbench
=========================================

// Module: spin_credit_controller
// PURPOSE
//  Game-flow controller between the player buttons and the reels animation engine.
//  - Accepts a spin request and deducts the bet from the credit meter.
//  - Pulses reels_start, then waits for reels_done.
//  - Latches the three stopped symbols and evaluates them against the paytable.
//  - Pays the win back into the credit meter one credit per tick, so the score display counts up.
// PARAMETERS
//  INIT_CREDITS  100     credit value after reset
//  MAX_CREDITS   9999    credit saturation ceiling (4-digit display)
//  TICK_DIV      2**20   clk cycles per credit during payout count-up (>=2)
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous reset, active-high
//  spin_req       in   1   single-cycle spin button pulse (already debounced)
//  bet_sel        in   2   bet 1..3 credits; 0 is treated as 1
//  reels_start    out  1   single-cycle start pulse to the reels engine
//  reels_done     in   1   single-cycle pulse: all reels have stopped
//  symbols        in   9   {reel2,reel1,reel0}, 3 bits each; stable when reels_done is high
//  credits        out  14  credit meter
//  bet            out  2   bet of the current/last spin (1..3)
//  win_amount     out  10  win of the last evaluated spin; held until the next spin is accepted
//  busy           out  1   high in every state except IDLE
//  payout_active  out  1   high while in PAYOUT
//  no_credit      out  1   single-cycle pulse: spin refused because credits < bet
// BEHAVIOUR
//  Reset: credits=INIT_CREDITS, bet=1, win_amount=0, all pulse/flag outputs 0, state=IDLE, tick counter 0.
//   rst mid-operation aborts any spin or payout; there is no credit refund.
//  All outputs are registered. One-hot FSM: IDLE, START, WAIT_REELS, EVAL, PAYOUT.
//  IDLE
//   - spin_req with credits>=eff_bet: next cycle credits-=eff_bet, bet=eff_bet, win_amount=0,
//     reels_start=1, state goes to START.
//   - spin_req with credits<eff_bet: no_credit=1 for one cycle; state and credits unchanged.
//  START (1 cycle): reels_start returns to 0; go to WAIT_REELS.
//  WAIT_REELS: on reels_done, latch symbols into sym_r and go to EVAL. No timeout.
//  EVAL (1 cycle): win_amount = bet * mult. If mult==0 go to IDLE, else load remain=win_amount,
//   clear the tick counter and go to PAYOUT.
//  mult rule, s0..s2 = reels 0..2:
//   - s0==s1==s2: mult = PAY3[s0].
//   - otherwise cherries (symbol 0) count n: n==2 gives 5, n==1 gives 2, else 0.
//  Width: bet(2b) * mult(8b) gives at most 600; fits 10 bits.
//  PAYOUT
//   - Tick counter counts 0..TICK_DIV-1.
//   - On the terminal count: credits+=1, remain-=1.
//   - When remain reaches 0, or credits==MAX_CREDITS, go to IDLE. At saturation the rest of the win
//     is discarded and win_amount still shows the full win.
//  Ignored inputs:
//   - spin_req while busy (no queueing, no no_credit pulse).
//   - reels_done outside WAIT_REELS.
//   - bet_sel changes after acceptance.
//  Simultaneous spin_req and reels_done in IDLE: only spin_req acts.
//  The credit subtraction never underflows because it is guarded by the credits>=eff_bet check.
// STRUCTURE
//  Package slot_defs_pkg (shared with reels_engine and the display):
//   - SYM_W=3, symbol codes with SYM_CHERRY=0
//   - PAY3[0..7] = 10,15,20,25,40,50,100,200
//   - CREDIT_W=14, WIN_W=10
//   - state encodings
//  Sub-module pay_calc: combinational symbols[8:0], bet[1:0] -> win[9:0]. Its output is registered in EVAL.
// TESTING
//  1 Reset, then spin_req with bet_sel=2 -> reels_start one cycle later, credits 100->98, busy=1.
//  2 Same spin, reels_done with symbols {7,7,7} -> win_amount=400, then credits reach 498 after 400 ticks,
//    payout_active falls, busy=0.
//  3 bet_sel=0, symbols {0,3,0} -> bet=1, win=5; symbols {1,2,3} -> win=0, no PAYOUT, IDLE after EVAL.
//  4 Credits forced to 2 (repeated losing spins), bet_sel=3 -> no_credit pulse, credits stay 2, reels_start=0.
//  5 Credits 9990 at payout start, win=30 -> credits saturate at 9999, FSM returns to IDLE,
//    win_amount stays 30.
//  6 spin_req in WAIT_REELS and in PAYOUT ignored; rst asserted mid-PAYOUT -> credits=100,
//    all outputs back to reset values on the next edge.

Source files
------------

// File: rtl/slot_defs_pkg.sv
// Shared slot-machine definitions: symbol codes, widths, paytable, FSM states.
// Used by the spin/credit controller, the reels engine and the display.
package slot_defs_pkg;

    localparam int SYM_W    = 3;
    localparam int CREDIT_W = 14;
    localparam int WIN_W    = 10;
    localparam int MULT_W   = 8;

    localparam logic [SYM_W-1:0] SYM_CHERRY = 3'd0;

    // One-hot controller states
    typedef enum logic [4:0] {
        ST_IDLE       = 5'b00001,
        ST_START      = 5'b00010,
        ST_WAIT_REELS = 5'b00100,
        ST_EVAL       = 5'b01000,
        ST_PAYOUT     = 5'b10000
    } state_t;

    // Three-of-a-kind multiplier for each symbol code
    function automatic logic [MULT_W-1:0] pay3(input logic [SYM_W-1:0] sym);
        logic [MULT_W-1:0] m;
        case (sym)
            3'd0:    m = 8'd10;
            3'd1:    m = 8'd15;
            3'd2:    m = 8'd20;
            3'd3:    m = 8'd25;
            3'd4:    m = 8'd40;
            3'd5:    m = 8'd50;
            3'd6:    m = 8'd100;
            default: m = 8'd200;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pay_calc.sv
// Combinational paytable evaluation: stopped symbols and bet -> win amount.
// Ports: symbols {reel2,reel1,reel0}, bet (1..3), win = bet * multiplier.
module pay_calc
    import slot_defs_pkg::*;
(
    input  logic [3*SYM_W-1:0] symbols,
    input  logic [1:0]         bet,
    output logic [WIN_W-1:0]   win
);

    logic [SYM_W-1:0]  s0;
    logic [SYM_W-1:0]  s1;
    logic [SYM_W-1:0]  s2;
    logic [1:0]        cherries;
    logic [MULT_W-1:0] mult;

    assign s0 = symbols[SYM_W-1:0];
    assign s1 = symbols[2*SYM_W-1:SYM_W];
    assign s2 = symbols[3*SYM_W-1:2*SYM_W];

    always_comb begin
        cherries = 2'(s0 == SYM_CHERRY)
                 + 2'(s1 == SYM_CHERRY)
                 + 2'(s2 == SYM_CHERRY);
        mult = '0;
        // Three-of-a-kind (including three cherries) takes priority
        if (s0 == s1 && s1 == s2) begin
            mult = pay3(s0);
        end else if (cherries == 2'd2) begin
            mult = 8'd5;
        end else if (cherries == 2'd1) begin
            mult = 8'd2;
        end
    end

    // 2-bit bet * 8-bit mult peaks at 600, fits WIN_W
    assign win = WIN_W'(bet) * WIN_W'(mult);

endmodule

// File: rtl/spin_credit_controller.sv
// Game-flow controller: takes spin requests, charges the bet, starts the reels,
// evaluates the stopped symbols and counts the win back into the credit meter.
// Ports: clk/rst (sync, active-high), spin_req, bet_sel, reels_start,
//   reels_done, symbols, credits, bet, win_amount, busy, payout_active, no_credit.
module spin_credit_controller
    import slot_defs_pkg::*;
#(
    parameter int INIT_CREDITS = 100,
    parameter int MAX_CREDITS  = 9999,
    parameter int TICK_DIV     = 2**20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                spin_req,
    input  logic [1:0]          bet_sel,
    output logic                reels_start,
    input  logic                reels_done,
    input  logic [3*SYM_W-1:0]  symbols,
    output logic [CREDIT_W-1:0] credits,
    output logic [1:0]          bet,
    output logic [WIN_W-1:0]    win_amount,
    output logic                busy,
    output logic                payout_active,
    output logic                no_credit
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [CREDIT_W-1:0] CRED_INIT = CREDIT_W'(INIT_CREDITS);
    localparam logic [CREDIT_W-1:0] CRED_MAX  = CREDIT_W'(MAX_CREDITS);

    state_t              state;
    logic [TICK_W-1:0]   tick;
    logic [WIN_W-1:0]    remain;
    logic [WIN_W-1:0]    win_calc;
    logic [3*SYM_W-1:0]  sym_r;
    logic [1:0]          eff_bet;
    logic                can_pay;

    assign eff_bet = (bet_sel == 2'd0) ? 2'd1 : bet_sel;
    assign can_pay = credits >= CREDIT_W'(eff_bet);

    // One-hot state bits are flops, so these flags are registered
    assign busy          = ~state[0];
    assign payout_active = state[4];

    pay_calc u_pay_calc (
        .symbols (sym_r),
        .bet     (bet),
        .win     (win_calc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            credits     <= CRED_INIT;
            bet         <= 2'd1;
            win_amount  <= '0;
            reels_start <= 1'b0;
            no_credit   <= 1'b0;
            tick        <= '0;
            remain      <= '0;
            sym_r       <= '0;
        end else begin
            reels_start <= 1'b0;
            no_credit   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (spin_req) begin
                        if (can_pay) begin
                            credits     <= credits - CREDIT_W'(eff_bet);
                            bet         <= eff_bet;
                            win_amount  <= '0;
                            reels_start <= 1'b1;
                            state       <= ST_START;
                        end else begin
                            no_credit <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    state <= ST_WAIT_REELS;
                end
                ST_WAIT_REELS: begin
                    if (reels_done) begin
                        sym_r <= symbols;
                        state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    win_amount <= win_calc;
                    if (win_calc == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        remain <= win_calc;
                        tick   <= '0;
                        state  <= ST_PAYOUT;
                    end
                end
                ST_PAYOUT: begin
                    if (tick == TICK_LAST) begin
                        tick   <= '0;
                        remain <= remain - WIN_W'(1);
                        if (credits != CRED_MAX) begin
                            credits <= credits + CREDIT_W'(1);
                        end
                        // Leave on the last credit or when the meter saturates;
                        // any unpaid remainder is dropped
                        if (remain == WIN_W'(1) ||
                            credits >= CRED_MAX - CREDIT_W'(1)) begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spin_credit_controller.sv
// Self-checking bench for spin_credit_controller: directed scenarios plus
// randomized spins compared against a behavioural credit/paytable model.
module tb_spin_credit_controller;

    localparam int TICK_DIV = 2;
    localparam int MAXC     = 9999;
    localparam int INITC    = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        spin_req;
    logic [1:0]  bet_sel;
    logic        reels_start;
    logic        reels_done;
    logic [8:0]  symbols;
    logic [13:0] credits;
    logic [1:0]  bet;
    logic [9:0]  win_amount;
    logic        busy;
    logic        payout_active;
    logic        no_credit;

    int checks   = 0;
    int failures = 0;
    int m_credits;
    int m_bet;
    int m_win;

    localparam logic [8:0] LOSE    = 9'b001_010_011;
    localparam logic [8:0] JACKPOT = 9'b111_111_111;

    spin_credit_controller #(
        .INIT_CREDITS (INITC),
        .MAX_CREDITS  (MAXC),
        .TICK_DIV     (TICK_DIV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .spin_req      (spin_req),
        .bet_sel       (bet_sel),
        .reels_start   (reels_start),
        .reels_done    (reels_done),
        .symbols       (symbols),
        .credits       (credits),
        .bet           (bet),
        .win_amount    (win_amount),
        .busy          (busy),
        .payout_active (payout_active),
        .no_credit     (no_credit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Paytable rules evaluated directly on symbol values
    function automatic int ref_mult(input logic [8:0] sy);
        int pay[8] = '{10, 15, 20, 25, 40, 50, 100, 200};
        int s[3];
        int n;
        for (int i = 0; i < 3; i++) s[i] = int'(sy[3*i +: 3]);
        if (s[0] == s[1] && s[1] == s[2]) return pay[s[0]];
        n = 0;
        for (int i = 0; i < 3; i++) if (s[i] == 0) n++;
        if (n == 2) return 5;
        if (n == 1) return 2;
        return 0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_credits"}, 32'(credits), INITC);
        check({tag, "_bet"}, 32'(bet), 1);
        check({tag, "_win"}, 32'(win_amount), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_payout"}, 32'(payout_active), 0);
        check({tag, "_start"}, 32'(reels_start), 0);
        check({tag, "_nocredit"}, 32'(no_credit), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        m_credits = INITC;
        m_bet     = 1;
        m_win     = 0;
    endtask

    task automatic request(input logic [1:0] bs, output bit accepted);
        int eb;
        eb = (bs == 2'd0) ? 1 : int'(bs);
        @(negedge clk);
        spin_req = 1'b1;
        bet_sel  = bs;
        @(negedge clk);
        spin_req = 1'b0;
        bet_sel  = 2'($urandom);
        if (m_credits < eb) begin
            check("refuse_nocredit", 32'(no_credit), 1);
            check("refuse_start", 32'(reels_start), 0);
            check("refuse_credits", 32'(credits), m_credits);
            check("refuse_busy", 32'(busy), 0);
            @(negedge clk);
            check("nocredit_pulse", 32'(no_credit), 0);
            accepted = 1'b0;
        end else begin
            m_credits -= eb;
            m_bet = eb;
            m_win = 0;
            check("accept_start", 32'(reels_start), 1);
            check("accept_credits", 32'(credits), m_credits);
            check("accept_bet", 32'(bet), m_bet);
            check("accept_win_clr", 32'(win_amount), 0);
            check("accept_busy", 32'(busy), 1);
            @(negedge clk);
            check("start_pulse_end", 32'(reels_start), 0);
            accepted = 1'b1;
        end
    endtask

    task automatic reels_stop(input logic [8:0] sy, input bit probe);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        if (probe) begin
            spin_req = 1'b1;
            @(negedge clk);
            spin_req = 1'b0;
            check("wait_ignore_busy", 32'(busy), 1);
            check("wait_ignore_credits", 32'(credits), m_credits);
            check("wait_ignore_start", 32'(reels_start), 0);
        end
        reels_done = 1'b1;
        symbols    = sy;
        @(negedge clk);
        reels_done = 1'b0;
        symbols    = 9'($urandom);
        @(negedge clk);
        m_win = m_bet * ref_mult(sy);
        check("win_amount", 32'(win_amount), m_win);
    endtask

    task automatic payout(input bit probe);
        int n_exp;
        int cyc;
        n_exp = m_win;
        if (m_credits + n_exp > MAXC) n_exp = MAXC - m_credits;
        cyc = 0;
        while (payout_active === 1'b1 && cyc < m_win * TICK_DIV + 10) begin
            spin_req = (probe && cyc == 1);
            cyc++;
            @(negedge clk);
        end
        spin_req = 1'b0;
        m_credits += n_exp;
        check("payout_cycles", cyc, n_exp * TICK_DIV);
        check("end_credits", 32'(credits), m_credits);
        check("end_busy", 32'(busy), 0);
        check("end_payout", 32'(payout_active), 0);
        check("end_win_hold", 32'(win_amount), m_win);
        check("end_bet", 32'(bet), m_bet);
    endtask

    task automatic full_spin(input logic [1:0] bs, input logic [8:0] sy,
                             input bit probe);
        bit acc;
        request(bs, acc);
        if (acc) begin
            reels_stop(sy, probe);
            payout(probe);
        end
    endtask

    initial begin
        bit acc;
        int target;
        logic [2:0] s;
        logic [8:0] sy;
        rst        = 1'b1;
        spin_req   = 1'b0;
        bet_sel    = 2'd0;
        reels_done = 1'b0;
        symbols    = '0;
        repeat (3) @(negedge clk);
        do_reset();

        // reels_done while idle is ignored
        reels_done = 1'b1;
        @(negedge clk);
        reels_done = 1'b0;
        @(negedge clk);
        check("idle_done_busy", 32'(busy), 0);

        // Bet 2, triple 7 -> 400 counted up to 498
        full_spin(2'd2, JACKPOT, 1'b0);
        check("t2_credits", 32'(credits), 498);

        // Bet 0 acts as 1; two cherries pay 5
        full_spin(2'd0, 9'b000_011_000, 1'b0);
        check("t3_win", 32'(win_amount), 5);
        // No win: straight back to idle
        full_spin(2'd0, LOSE, 1'b0);
        check("t3_lose_win", 32'(win_amount), 0);

        // Ignored spin_req in WAIT_REELS and PAYOUT, then reset mid-payout
        request(2'd3, acc);
        reels_stop(JACKPOT, 1'b1);
        repeat (6) @(negedge clk);
        check("t6_in_payout", 32'(payout_active), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        m_credits = INITC;
        m_bet     = 1;
        m_win     = 0;

        // Drain to 2 credits with losing spins, then a 3-credit bet is refused
        full_spin(2'd2, LOSE, 1'b0);
        repeat (32) full_spin(2'd3, LOSE, 1'b0);
        check("t4_credits", 32'(credits), 2);
        full_spin(2'd3, LOSE, 1'b0);
        check("t4_still2", 32'(credits), 2);

        do_reset();

        // Randomized spins
        repeat (25) begin
            if ($urandom_range(0, 3) == 0) begin
                s  = 3'($urandom);
                sy = {s, s, s};
            end else begin
                sy = 9'($urandom);
            end
            full_spin(2'($urandom), sy, 1'($urandom));
        end

        // Climb to 9993 so a bet-3 triple cherry starts payout at 9990
        target = 9993;
        while (m_credits + 597 <= target) full_spin(2'd3, JACKPOT, 1'b0);
        while (m_credits + 199 <= target) full_spin(2'd1, JACKPOT, 1'b0);
        while (m_credits + 4 <= target) full_spin(2'd1, 9'b000_000_001, 1'b0);
        while (m_credits + 1 <= target) full_spin(2'd1, 9'b001_010_000, 1'b0);
        check("t5_pre", 32'(credits), 9993);
        full_spin(2'd3, 9'b000_000_000, 1'b0);
        check("t5_sat", 32'(credits), 9999);
        check("t5_win", 32'(win_amount), 30);
        check("t5_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
